// File: rtl/pio_irq_event_master_pkg.sv
// Shared types and constants for the PIO edge-capture event master.
package pio_irq_event_master_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT,
    S_RDE_A,
    S_RDE_D,
    S_CLR,
    S_RDL_A,
    S_RDL_D,
    S_PUSH
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Event word layout: {timestamp, level[3:0], edges[3:0]}
  localparam int EDGE_LSB  = 0;
  localparam int LEVEL_LSB = 4;
  localparam int TS_LSB    = 8;

endpackage

// File: rtl/pio_irq_event_master_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only if a pop happens in the same cycle.
module pio_event_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign valid   = (count != '0);
  assign pop_ok  = pop & valid;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/pio_irq_event_master.sv
// Avalon-MM host that services a 4-bit edge-capture PIO and queues timestamped events.
module pio_irq_event_master
  import pio_irq_event_master_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [3:0]      mask_cfg,
  input  logic            irq,
  output logic [1:0]      address,
  output logic            chipselect,
  output logic            write_n,
  output logic [31:0]     writedata,
  input  logic [31:0]     readdata,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [TS_W+7:0] evt_data,
  output logic            overflow,
  input  logic            overflow_clr
);

  state_t          state;
  logic            enable_d;
  logic            init_pend;
  logic            enable_rise;
  logic [TS_W-1:0] timestamp;
  logic [TS_W-1:0] ts_evt;
  logic [3:0]      edges;
  logic            fifo_push;
  logic            fifo_drop;
  logic [TS_W+7:0] fifo_wdata;
  logic            unused_readdata;

  assign unused_readdata = ^readdata[31:4];
  assign enable_rise     = enable & ~enable_d;
  assign fifo_push       = (state == S_PUSH) && ((edges & mask_cfg) != 4'b0);

  always_comb begin
    fifo_wdata = '0;
    fifo_wdata[TS_LSB +: TS_W]  = ts_evt;
    fifo_wdata[LEVEL_LSB +: 4]  = readdata[3:0];
    fifo_wdata[EDGE_LSB +: 4]   = edges;
  end

  always_ff @(posedge clk) begin
    if (reset) timestamp <= '0;
    else       timestamp <= timestamp + 1'b1;
  end

  // Bus registers are loaded with the current state's action, so each action
  // is on the bus one cycle after its state. The second cycle of a read thus
  // coincides with the following state, which is where readdata is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      address    <= ADDR_DATA;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      enable_d   <= 1'b0;
      init_pend  <= 1'b0;
      ts_evt     <= '0;
      edges      <= '0;
    end else begin
      enable_d <= enable;
      if (enable_rise && state != S_WAIT) init_pend <= 1'b1;
      case (state)
        S_INIT: begin
          address    <= ADDR_MASK;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          writedata  <= {28'b0, mask_cfg};
          state      <= S_WAIT;
        end
        S_WAIT: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          if (enable_rise || init_pend) begin
            init_pend <= 1'b0;
            state     <= S_INIT;
          end else if (enable && irq) begin
            ts_evt <= timestamp;
            state  <= S_RDE_A;
          end
        end
        S_RDE_A, S_RDE_D: begin
          address    <= ADDR_EDGE;
          chipselect <= 1'b1;
          write_n    <= 1'b1;
          state      <= (state == S_RDE_A) ? S_RDE_D : S_CLR;
        end
        S_CLR: begin
          edges      <= readdata[3:0];
          address    <= ADDR_EDGE;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          writedata  <= '0;
          state      <= S_RDL_A;
        end
        S_RDL_A, S_RDL_D: begin
          address    <= ADDR_DATA;
          chipselect <= 1'b1;
          write_n    <= 1'b1;
          state      <= (state == S_RDL_A) ? S_RDL_D : S_PUSH;
        end
        default: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          state      <= S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             overflow <= 1'b0;
    else if (fifo_drop)    overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  pio_event_fifo #(
    .W     (TS_W + 8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (evt_ready),
    .valid (evt_valid),
    .rdata (evt_data),
    .drop  (fifo_drop)
  );

endmodule
